irq_service_sequencer: RTL and testbench
========================================

// Module: irq_service_sequencer
// PURPOSE
//  Sequences interrupt servicing for the POKEY IRQ core. On IRQ it samples IRQST
//  (core Dr) and priority-encodes the highest enabled source into a vector for the host.
//  It clears that source by pulsing its IRQEN bit low, then restores the mask.
//  Sole owner of the IRQ core's IRQEN/Dw write port; host mask writes arbitrate through it.
// PARAMETERS
//  HOLD_STROBES   2  en strobes each IRQEN write (clear, restore) is held; min 2
//  GUARD_STROBES  2  en strobes after vec_ack before IRQ is re-sampled; min 1
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  nreset      in   1  asynchronous active-low reset
//  en          in   1  core cycle strobe, same phase as the IRQ core's enn
//  irq         in   1  IRQ core IRQ output, active high
//  irqst       in   8  IRQ core Dr: 1 = pending; bit3 = level "serial out done"
//  mask_we     in   1  host IRQEN write request, one clk pulse
//  mask_in     in   8  host IRQEN value
//  irqen_we    out  1  to IRQ core IRQEN
//  irqen_dw    out  8  to IRQ core Dw
//  vec_valid   out  1  vector available; held until vec_ack
//  vec_id      out  3  source: 7 break,6 key,5 sdi,4 sdo,3 sdo-done,2 T4,1 T2,0 T1
//  vec_ack     in   1  host consumed vector; valid only while vec_valid=1
//  busy        out  1  FSM not in IDLE
//  spur_cnt    out  8  spurious IRQ count, saturating
// BEHAVIOUR
//  Reset: all outputs 0; mask shadow=8'h00; FSM=IDLE; sdo_seen=0; counters 0.
//  States: IDLE, SAMPLE, CLEAR, RESTORE, VECTOR, GUARD.
//  IDLE: mask_we -> irqen_we=1, irqen_dw=mask_in, shadow<=mask_in for HOLD_STROBES en
//   strobes (stay IDLE, busy=0). Else irq=1 and en=1 -> SAMPLE.
//   mask_we and irq in same clk: mask write first; irq re-checked afterwards.
//  SAMPLE (1 clk): p = irqst & shadow; bit3 of p forced 0 if sdo_seen=1.
//   p==0 -> spur_cnt+1 (hold at 255), -> GUARD. Else vec_id = index of highest set bit.
//   vec_id==3 -> sdo_seen<=1, -> VECTOR (bit3 not clearable; no IRQEN cycle).
//   else -> CLEAR.
//  CLEAR: irqen_we=1, irqen_dw = shadow & ~(1<<vec_id) for HOLD_STROBES en strobes.
//   -> RESTORE.
//  RESTORE: irqen_we=1, irqen_dw=shadow for HOLD_STROBES en strobes -> VECTOR.
//  VECTOR: vec_valid=1, vec_id stable. vec_ack -> vec_valid=0 next clk -> GUARD.
//  GUARD: count GUARD_STROBES en strobes (IRQ core re-registers IRQ) -> IDLE.
//  irqen_we is 0 outside the windows above; irqen_dw holds its last value.
//  Host mask_we while busy: latched in one-deep pending reg (later write overwrites).
//   Applied to shadow at RESTORE entry, so restore writes new mask. If service skips
//   RESTORE (bit3/spurious), applied on IDLE entry as a normal IDLE write.
//  sdo_seen clears on any clk with irqst[3]=0. Prevents re-vectoring level bit3.
//  Strobe counts advance only on clks with en=1; vec_ack/mask_we act every clk.
//  Latency: irq+en in IDLE -> vec_valid = 1 + 2*HOLD_STROBES strobes (+1 clk), min.
//  vec_ack while vec_valid=0: ignored. irq drop mid-service: sequence completes.
//  Reset mid-service: immediate async return to reset state; irqen_we=0 at once.
//   Mask shadow lost; host must rewrite IRQEN.
// TESTING
//  1 Reset: nreset=0 mid-CLEAR -> irqen_we=0, vec_valid=0, busy=0, shadow=00 at once.
//  2 Priority: mask_in=FF, irqst=8'b0100_0101, irq=1 -> vec_id=6.
//    Dw=BF for 2 strobes, then FF for 2 strobes; vec_valid=1 until vec_ack.
//  3 Masking: shadow=0x03, irqst=0x84 -> spurious; spur_cnt 0->1, no irqen_we, GUARD->IDLE.
//    Repeat 300x -> spur_cnt=255.
//  4 Bit3: shadow=08, irqst[3] held 1 -> one vector id=3, no IRQEN cycle, no repeat.
//    irqst[3] low then high -> second vector.
//  5 Deferred mask: mask_we=0x0F during CLEAR of id 1 -> RESTORE writes Dw=0F.
//    Two writes while busy -> last value used.
//  6 Collision: mask_we and irq same clk in IDLE -> mask write (2 strobes) precedes SAMPLE.

Source files
------------

// File: rtl/irq_service_sequencer_if.sv
// Bundle of the IRQ-core side and host side signals of the interrupt service sequencer.
// Latency: none, wires only.
// Backpressure: vec_valid is held until vec_ack; the host side never stalls IRQEN writes.
//
// Port summary (slave = sequencer):
//   en        in   core cycle strobe          irq       in   IRQ core IRQ output
//   irqst     in   IRQ core Dr (pending)      mask_we   in   host IRQEN write pulse
//   mask_in   in   host IRQEN value           vec_ack   in   host consumed vector
//   irqen_we  out  IRQEN write enable         irqen_dw  out  IRQEN write data
//   vec_valid out  vector available           vec_id    out  source index 0..7
//   busy      out  service in progress        spur_cnt  out  saturating spurious count
interface irq_service_sequencer_if;
    logic       en;
    logic       irq;
    logic [7:0] irqst;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       irqen_we;
    logic [7:0] irqen_dw;
    logic       vec_valid;
    logic [2:0] vec_id;
    logic       vec_ack;
    logic       busy;
    logic [7:0] spur_cnt;

    modport slave (
        input  en, irq, irqst, mask_we, mask_in, vec_ack,
        output irqen_we, irqen_dw, vec_valid, vec_id, busy, spur_cnt
    );

    modport master (
        output en, irq, irqst, mask_we, mask_in, vec_ack,
        input  irqen_we, irqen_dw, vec_valid, vec_id, busy, spur_cnt
    );
endinterface

// File: rtl/irq_service_sequencer.sv
// Samples the IRQ core on IRQ, vectors the highest enabled source, clears it by pulsing
// its IRQEN bit low and restores the mask; sole owner of the IRQEN write port.
// Latency: irq+en in IDLE -> vec_valid after 1 + 2*HOLD_STROBES en strobes (+1 clk).
// Backpressure: vec_valid held until vec_ack; host mask writes while busy are deferred.
//
// Ports: clk, nreset (async active-low); bus = irq_service_sequencer_if.slave.
module irq_service_sequencer #(
    parameter int HOLD_STROBES  = 2,
    parameter int GUARD_STROBES = 2
) (
    input  logic                          clk,
    input  logic                          nreset,
    irq_service_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_CLEAR, S_RESTORE, S_VECTOR, S_GUARD
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;           // en strobes spent in the current window
    logic [7:0] shadow_q, shadow_d;     // copy of the mask last written to IRQEN
    logic [7:0] dw_q, dw_d;
    logic [7:0] pend_val_q, pend_val_d; // host write received while busy
    logic       pend_vld_q, pend_vld_d;
    logic       wr_act_q, wr_act_d;     // host IRQEN write window running in IDLE
    logic       sdo_seen_q, sdo_seen_d; // level bit3 already vectored
    logic [2:0] id_q, id_d;
    logic [7:0] spur_q, spur_d;

    logic [7:0] pend_now;
    logic [2:0] hi_idx;
    logic       hold_done;
    logic       guard_done;

    assign hold_done  = bus.en && (cnt_q == 8'(HOLD_STROBES - 1));
    assign guard_done = bus.en && (cnt_q == 8'(GUARD_STROBES - 1));

    // Enabled pending sources; bit3 is a level that cannot be cleared through IRQEN,
    // so once vectored it is hidden until the core drops it.
    always_comb begin
        pend_now = bus.irqst & shadow_q;
        if (sdo_seen_q) begin
            pend_now[3] = 1'b0;
        end
        hi_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_now[i]) begin
                hi_idx = 3'(i);
            end
        end
    end

    // State register and datapath flops
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            shadow_q   <= 8'h00;
            dw_q       <= 8'h00;
            pend_val_q <= 8'h00;
            pend_vld_q <= 1'b0;
            wr_act_q   <= 1'b0;
            sdo_seen_q <= 1'b0;
            id_q       <= 3'd0;
            spur_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            dw_q       <= dw_d;
            pend_val_q <= pend_val_d;
            pend_vld_q <= pend_vld_d;
            wr_act_q   <= wr_act_d;
            sdo_seen_q <= sdo_seen_d;
            id_q       <= id_d;
            spur_q     <= spur_d;
        end
    end

    // Next state. In IDLE any host write (direct or deferred) goes ahead of a new service.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!wr_act_q && !bus.mask_we && !pend_vld_q && bus.irq && bus.en) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (pend_now == 8'h00)  state_d = S_GUARD;
                else if (hi_idx == 3'd3) state_d = S_VECTOR;
                else                     state_d = S_CLEAR;
            end
            S_CLEAR:   if (hold_done)   state_d = S_RESTORE;
            S_RESTORE: if (hold_done)   state_d = S_VECTOR;
            S_VECTOR:  if (bus.vec_ack) state_d = S_GUARD;
            S_GUARD:   if (guard_done)  state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        dw_d       = dw_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        wr_act_d   = wr_act_q;
        id_d       = id_q;
        spur_d     = spur_q;
        sdo_seen_d = bus.irqst[3] ? sdo_seen_q : 1'b0;

        // Writes that cannot go to IRQEN right now; a later one overwrites an earlier one.
        if (bus.mask_we && (state_q != S_IDLE || wr_act_q)) begin
            pend_vld_d = 1'b1;
            pend_val_d = bus.mask_in;
        end

        unique case (state_q)
            S_IDLE: begin
                if (wr_act_q) begin
                    if (bus.en) begin
                        cnt_d = cnt_q + 8'd1;
                        if (hold_done) begin
                            wr_act_d = 1'b0;
                            cnt_d    = 8'd0;
                        end
                    end
                end else if (bus.mask_we || pend_vld_q) begin
                    wr_act_d   = 1'b1;
                    cnt_d      = 8'd0;
                    shadow_d   = bus.mask_we ? bus.mask_in : pend_val_q;
                    dw_d       = bus.mask_we ? bus.mask_in : pend_val_q;
                    pend_vld_d = 1'b0;
                end
            end
            S_SAMPLE: begin
                cnt_d = 8'd0;
                if (pend_now == 8'h00) begin
                    spur_d = (spur_q == 8'hFF) ? spur_q : spur_q + 8'd1;
                end else begin
                    id_d = hi_idx;
                    if (hi_idx == 3'd3) sdo_seen_d = 1'b1;
                    else                dw_d = shadow_q & ~(8'h01 << hi_idx);
                end
            end
            S_CLEAR: begin
                if (bus.en) begin
                    cnt_d = cnt_q + 8'd1;
                    if (hold_done) begin
                        // A deferred host mask becomes the value restored.
                        cnt_d      = 8'd0;
                        shadow_d   = pend_vld_q ? pend_val_q : shadow_q;
                        dw_d       = pend_vld_q ? pend_val_q : shadow_q;
                        pend_vld_d = bus.mask_we;
                    end
                end
            end
            S_RESTORE, S_GUARD: begin
                if (bus.en) begin
                    cnt_d = cnt_q + 8'd1;
                    if ((state_q == S_RESTORE) ? hold_done : guard_done) begin
                        cnt_d = 8'd0;
                    end
                end
            end
            default: cnt_d = 8'd0;
        endcase
    end

    assign bus.irqen_we  = (state_q == S_IDLE && wr_act_q) ||
                           (state_q == S_CLEAR) || (state_q == S_RESTORE);
    assign bus.irqen_dw  = dw_q;
    assign bus.vec_valid = (state_q == S_VECTOR);
    assign bus.vec_id    = id_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.spur_cnt  = spur_q;

endmodule

// File: tb/tb_irq_service_sequencer.sv
// Randomized bench for irq_service_sequencer; reference model works per service
// transaction (mask, pending byte, expected vector, expected IRQEN write runs).
module tb_irq_service_sequencer;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    irq_service_sequencer_if bif();

    irq_service_sequencer #(.HOLD_STROBES(2), .GUARD_STROBES(2)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bif)
    );

    // One run of IRQEN writes: value and number of en strobes it was held for.
    typedef struct {
        logic [7:0] dw;
        int         n;
    } seg_t;

    seg_t       seg_q[$];
    int         vectors = 0;
    int         errors  = 0;
    bit         en_hold = 1'b0;
    logic [7:0] m_shadow;
    bit         m_sdo;
    int         m_spur;

    // Observe IRQEN write runs on the falling edge.
    initial begin : mon
        bit   open;
        seg_t cur;
        open = 1'b0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                open = 1'b0;
            end else if (bif.irqen_we === 1'b1) begin
                if (open && bif.irqen_dw === cur.dw) begin
                    if (bif.en) cur.n++;
                end else begin
                    if (open) seg_q.push_back(cur);
                    open   = 1'b1;
                    cur.dw = bif.irqen_dw;
                    cur.n  = bif.en ? 1 : 0;
                end
            end else if (open) begin
                seg_q.push_back(cur);
                open = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        bif.en = en_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_reset();
        m_shadow = 8'h00;
        m_sdo    = 1'b0;
        m_spur   = 0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        step();
        step();
        nreset = 1'b1;
        step();
        model_reset();
        seg_q.delete();
    endtask

    task automatic write_mask(input logic [7:0] v);
        int t;
        bif.mask_we = 1'b1;
        bif.mask_in = v;
        step();
        bif.mask_we = 1'b0;
        t = 0;
        while (bif.irqen_we !== 1'b1 && t < 50) begin step(); t++; end
        while (bif.irqen_we === 1'b1 && t < 100) begin step(); t++; end
        step();
        m_shadow = v;
        vectors++;
        if (t >= 100 || seg_q.size() != 1 || seg_q[0].dw !== v || seg_q[0].n != 2) begin
            errors++;
            $display("FAIL mask_write: got %0d runs, first %h x%0d; want 1 run %h x2",
                     seg_q.size(), (seg_q.size() > 0) ? seg_q[0].dw : 8'hxx,
                     (seg_q.size() > 0) ? seg_q[0].n : -1, v);
        end
        seg_q.delete();
    endtask

    // One complete service. coll: host write in the same clk as irq. nwr: number of
    // host writes made during CLEAR. early_ack: vec_ack pulse before any vector.
    task automatic do_service(input logic [7:0] ist, input bit coll, input logic [7:0] cv,
                              input int nwr, input logic [7:0] w0, input logic [7:0] w1,
                              input int ack_dly, input bit early_ack);
        seg_t       exp_q[$];
        seg_t       s;
        logic [7:0] p;
        int         id, t, eff_nwr;
        bit         spur, normal, got, bad;
        logic [2:0] got_id;
        string      gs, es;

        exp_q.delete();
        seg_q.delete();
        bif.irqst = ist;
        if (!ist[3]) m_sdo = 1'b0;
        if (coll) begin
            m_shadow = cv;
            s.dw = cv; s.n = 2;
            exp_q.push_back(s);
        end
        p = ist & m_shadow;
        if (m_sdo) p[3] = 1'b0;
        spur   = (p == 8'h00);
        id     = spur ? -1 : $clog2({1'b0, p} + 9'd1) - 1;
        normal = !spur && id != 3;
        eff_nwr = nwr;
        if (normal) begin
            s.dw = m_shadow & ~(8'h01 << id); s.n = 2;
            exp_q.push_back(s);
            // a restore value equal to the clear value would be indistinguishable
            if (eff_nwr > 0 && ((eff_nwr == 2) ? w1 : w0) === s.dw) eff_nwr = 0;
            if (eff_nwr > 0) m_shadow = (eff_nwr == 2) ? w1 : w0;
            s.dw = m_shadow;
            exp_q.push_back(s);
        end
        if (id == 3) m_sdo = 1'b1;
        if (spur && m_spur < 255) m_spur++;

        bif.irq = 1'b1;
        if (coll) begin
            bif.mask_we = 1'b1;
            bif.mask_in = cv;
        end
        step();
        bif.mask_we = 1'b0;
        t = 0;
        while (bif.busy !== 1'b1 && t < 60) begin step(); t++; end
        bif.irq = 1'b0;

        if (normal && (eff_nwr > 0 || early_ack)) begin
            while (bif.irqen_we !== 1'b1 && t < 120) begin step(); t++; end
            if (eff_nwr > 0) begin
                en_hold     = 1'b1;
                bif.en      = 1'b0;
                bif.mask_we = 1'b1;
                bif.mask_in = w0;
                step();
                if (eff_nwr == 2) begin
                    bif.mask_in = w1;
                    step();
                end
                bif.mask_we = 1'b0;
                en_hold     = 1'b0;
            end else begin
                bif.vec_ack = 1'b1;
                step();
                bif.vec_ack = 1'b0;
            end
        end

        got    = 1'b0;
        got_id = 3'd0;
        while (t < 400) begin
            if (bif.vec_valid === 1'b1 && !got) begin
                got    = 1'b1;
                got_id = bif.vec_id;
                repeat (ack_dly) begin
                    step(); t++;
                    vectors++;
                    if (bif.vec_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL vec_hold: vec_valid=%b want 1 before ack", bif.vec_valid);
                    end
                end
                bif.vec_ack = 1'b1;
                step(); t++;
                bif.vec_ack = 1'b0;
                vectors++;
                if (bif.vec_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL vec_drop: vec_valid=%b want 0 after ack", bif.vec_valid);
                end
            end
            if (bif.busy === 1'b0) break;
            step(); t++;
        end
        step();

        vectors++;
        if (t >= 400) begin
            errors++;
            $display("FAIL service_timeout: irqst=%h busy=%b want idle", ist, bif.busy);
        end
        vectors++;
        if (got !== !spur) begin
            errors++;
            $display("FAIL vec_presence: irqst=%h got vector=%0d want %0d", ist, got, !spur);
        end
        if (!spur) begin
            vectors++;
            if (got_id !== 3'(id)) begin
                errors++;
                $display("FAIL vec_id: irqst=%h got %0d want %0d", ist, got_id, id);
            end
        end
        vectors++;
        if (bif.spur_cnt !== 8'(m_spur)) begin
            errors++;
            $display("FAIL spur_cnt: got %0d want %0d", bif.spur_cnt, m_spur);
        end
        vectors++;
        bad = (seg_q.size() != exp_q.size());
        for (int i = 0; i < seg_q.size() && i < exp_q.size(); i++) begin
            if (seg_q[i].dw !== exp_q[i].dw || seg_q[i].n != exp_q[i].n) bad = 1'b1;
        end
        if (bad) begin
            errors++;
            gs = ""; es = "";
            foreach (seg_q[i]) gs = {gs, $sformatf("%h x%0d ", seg_q[i].dw, seg_q[i].n)};
            foreach (exp_q[i]) es = {es, $sformatf("%h x%0d ", exp_q[i].dw, exp_q[i].n)};
            $display("FAIL irqen_seq: irqst=%h got [%s] want [%s]", ist, gs, es);
        end
        seg_q.delete();
    endtask

    task automatic test_reset();
        int t;
        nreset = 1'b0;
        step();
        step();
        vectors++;
        if ({bif.irqen_we, bif.vec_valid, bif.busy, bif.irqen_dw, bif.vec_id, bif.spur_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b vv=%b busy=%b dw=%h id=%0d spur=%0d want all 0",
                     bif.irqen_we, bif.vec_valid, bif.busy, bif.irqen_dw, bif.vec_id, bif.spur_cnt);
        end
        nreset = 1'b1;
        step();
        model_reset();
        vectors++;
        if ({bif.irqen_we, bif.vec_valid, bif.busy, bif.spur_cnt} !== 11'd0) begin
            errors++;
            $display("FAIL post_reset_idle: we=%b vv=%b busy=%b spur=%0d want all 0",
                     bif.irqen_we, bif.vec_valid, bif.busy, bif.spur_cnt);
        end
        write_mask(8'hFF);
        bif.irqst = 8'h02;
        bif.irq   = 1'b1;
        t = 0;
        while (bif.irqen_we !== 1'b1 && t < 60) begin step(); t++; end
        vectors++;
        if (t >= 60) begin
            errors++;
            $display("FAIL reach_clear: irqen_we=%b want 1", bif.irqen_we);
        end
        nreset = 1'b0;
        #1;
        vectors++;
        if (bif.irqen_we !== 1'b0 || bif.vec_valid !== 1'b0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midclear: we=%b vv=%b busy=%b want 0 0 0",
                     bif.irqen_we, bif.vec_valid, bif.busy);
        end
        bif.irq = 1'b0;
        step();
        step();
        nreset = 1'b1;
        step();
        model_reset();
        seg_q.delete();
        // mask shadow is back to 00, so everything pending is spurious
        do_service(8'hFF, 1'b0, 8'h00, 0, 8'h00, 8'h00, 0, 1'b0);
    endtask

    task automatic test_priority();
        do_reset();
        write_mask(8'hFF);
        do_service(8'b0100_0101, 1'b0, 8'h00, 0, 8'h00, 8'h00, 5, 1'b1);
    endtask

    task automatic test_masking();
        do_reset();
        write_mask(8'h03);
        for (int i = 0; i < 300; i++) begin
            do_service(8'h84, 1'b0, 8'h00, 0, 8'h00, 8'h00, 0, 1'b0);
        end
    endtask

    task automatic test_bit3();
        do_reset();
        write_mask(8'h08);
        do_service(8'h08, 1'b0, 8'h00, 0, 8'h00, 8'h00, 1, 1'b0);
        do_service(8'h08, 1'b0, 8'h00, 0, 8'h00, 8'h00, 1, 1'b0);
        bif.irqst = 8'h00;
        m_sdo     = 1'b0;
        repeat (3) step();
        do_service(8'h08, 1'b0, 8'h00, 0, 8'h00, 8'h00, 2, 1'b0);
    endtask

    task automatic test_deferred_mask();
        do_reset();
        write_mask(8'hFF);
        do_service(8'h02, 1'b0, 8'h00, 1, 8'h0F, 8'h00, 0, 1'b0);
        do_service(8'h02, 1'b0, 8'h00, 2, 8'h33, 8'h3C, 0, 1'b0);
    endtask

    task automatic test_collision();
        do_reset();
        write_mask(8'h01);
        do_service(8'h31, 1'b1, 8'h30, 0, 8'h00, 8'h00, 0, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) write_mask(8'($urandom));
            do_service(8'($urandom), 1'b0, 8'h00, $urandom_range(0, 2),
                       8'($urandom), 8'($urandom), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        nreset      = 1'b0;
        bif.en      = 1'b0;
        bif.irq     = 1'b0;
        bif.irqst   = 8'h00;
        bif.mask_we = 1'b0;
        bif.mask_in = 8'h00;
        bif.vec_ack = 1'b0;
        model_reset();

        test_reset();
        test_priority();
        test_masking();
        test_bit3();
        test_deferred_mask();
        test_collision();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
